// File: rtl/ethpipe_pkg.sv
// Shared definitions for the Ethernet RX slot path: slot word map, length
// field width, reader state encoding and the stream word record.
package ethpipe_pkg;

    localparam int LEN_W = 11;

    localparam logic [10:0] SLOT_TS_LO = 11'd1;
    localparam logic [10:0] SLOT_TS_HI = 11'd2;
    localparam logic [10:0] SLOT_HASH  = 11'd3;
    localparam logic [10:0] SLOT_LEN   = 11'd4;
    localparam logic [10:0] SLOT_DATA  = 11'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_CHECK,
        ST_STREAM,
        ST_DROP,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [3:0]  byte_en;
    } slot_word_t;

    // Valid bytes in the final data word, from the low two bits of the length.
    function automatic logic [3:0] last_byte_en(input logic [1:0] rem);
        case (rem)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ethpipe_skid2.sv
// Two-entry FIFO between the slot RAM read return and the output stream.
// Output side is driven purely from registers, so out_valid never depends on out_ready.
module ethpipe_skid2 #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_idx;
    logic         rd_idx;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_idx];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= in_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ethpipe_rx_slot_reader.sv
// Reads a completed RX frame slot (header words 1-4, then frame data) and streams
// it as 32-bit words to the host side, then hands the slot back to the receiver.
module ethpipe_rx_slot_reader
    import ethpipe_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1536,
    parameter int MIN_FRAME_LEN = 1
) (
    input  logic        pci_clk,
    input  logic        sys_rst,
    input  logic        slot_rx_complete,
    output logic        slot_rx_empty,
    output logic [10:0] slot_rd_address,
    input  logic [31:0] slot_rd_q,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [3:0]  out_byte_en,
    output logic [31:0] rx_frame_cnt,
    output logic [31:0] rx_drop_cnt,
    output logic        rx_overrun,
    output state_t      dbg_state
);

    // Stream handshake: a word transfers on a rising clk edge where out_valid and
    // out_ready are both high; while out_valid=1 and out_ready=0 every out_* field
    // holds its value, and out_valid is never a combinational function of out_ready.

    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

    state_t      state;
    state_t      state_next;
    logic [10:0] rd_ptr;
    logic        ret_valid;
    logic [10:0] ret_addr;
    logic [10:0] len_q;
    logic [10:0] last_addr;
    logic        forwarded;

    logic [10:0] len_in;
    logic [11:0] len_p3;
    logic [9:0]  n_words;
    logic [10:0] last_addr_in;
    logic        len_ok;

    slot_word_t  skid_in;
    slot_word_t  skid_out;
    logic        skid_in_ready;
    logic [1:0]  skid_count;
    logic        pop;
    logic [2:0]  credit_used;
    logic        all_issued;
    logic        issue;
    logic        drained;

    assign len_in       = slot_rd_q[LEN_W-1:0];
    assign len_p3       = {1'b0, len_in} + 12'd3;
    assign n_words      = len_p3[11:2];
    assign last_addr_in = SLOT_LEN + {1'b0, n_words};
    assign len_ok       = (len_in >= MIN_LEN) && (len_in <= MAX_LEN);

    // A word popped this cycle frees its slot in time for a read issued now,
    // which is what sustains one word per cycle through a two-entry buffer.
    assign pop         = out_valid && out_ready;
    assign credit_used = {1'b0, skid_count} + {2'b0, ret_valid} - {2'b0, pop};
    assign all_issued  = (rd_ptr > last_addr);
    assign issue       = (state == ST_STREAM) && !all_issued && (credit_used < 3'd2);
    assign drained     = all_issued && !ret_valid && (credit_used == 3'd0);

    assign slot_rd_address = rd_ptr;
    assign dbg_state       = state;

    always_ff @(posedge pci_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (slot_rx_complete) state_next = ST_LEN;
            ST_LEN:    state_next = ST_CHECK;
            ST_CHECK:  state_next = len_ok ? ST_STREAM : ST_DROP;
            ST_STREAM: if (drained) state_next = ST_DONE;
            ST_DROP:   state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pci_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_ptr        <= 11'd0;
            ret_valid     <= 1'b0;
            ret_addr      <= 11'd0;
            len_q         <= 11'd0;
            last_addr     <= 11'd0;
            forwarded     <= 1'b0;
            slot_rx_empty <= 1'b1;
            rx_frame_cnt  <= 32'd0;
            rx_drop_cnt   <= 32'd0;
            rx_overrun    <= 1'b0;
        end else begin
            ret_valid <= issue;
            ret_addr  <= rd_ptr;

            if (state == ST_IDLE && slot_rx_complete) begin
                rd_ptr        <= SLOT_LEN;
                slot_rx_empty <= 1'b0;
            end else if (state == ST_CHECK) begin
                len_q     <= len_in;
                last_addr <= last_addr_in;
                forwarded <= len_ok;
                if (len_ok) rd_ptr <= SLOT_TS_LO;
            end else if (issue) begin
                rd_ptr <= rd_ptr + 11'd1;
            end

            if (state != ST_DONE && state_next == ST_DONE) slot_rx_empty <= 1'b1;
            if (state == ST_DROP) rx_drop_cnt <= rx_drop_cnt + 32'd1;
            if (state == ST_DONE && forwarded) rx_frame_cnt <= rx_frame_cnt + 32'd1;
            if (slot_rx_complete && state != ST_IDLE) rx_overrun <= 1'b1;
        end
    end

    always_comb begin
        skid_in.data    = slot_rd_q;
        skid_in.sop     = (ret_addr == SLOT_TS_LO);
        skid_in.eop     = (ret_addr == last_addr);
        skid_in.byte_en = skid_in.eop ? last_byte_en(len_q[1:0]) : 4'b1111;
    end

    ethpipe_skid2 #(
        .W($bits(slot_word_t))
    ) u_skid (
        .clk      (pci_clk),
        .rst      (sys_rst),
        .in_data  (skid_in),
        .in_valid (ret_valid && skid_in_ready),
        .in_ready (skid_in_ready),
        .out_data (skid_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (skid_count)
    );

    assign out_data    = skid_out.data;
    assign out_sop     = skid_out.sop;
    assign out_eop     = skid_out.eop;
    assign out_byte_en = skid_out.byte_en;

endmodule

// File: tb/tb_ethpipe_rx_slot_reader.sv
// Bench for ethpipe_rx_slot_reader: random slot contents, a word-list reference
// of each record, and per-scenario tasks with inline comparisons.
`timescale 1ns/1ps
module tb_ethpipe_rx_slot_reader;
    import ethpipe_pkg::*;

    logic        pci_clk = 1'b0;
    logic        sys_rst;
    logic        slot_rx_complete;
    logic        slot_rx_empty;
    logic [10:0] slot_rd_address;
    logic [31:0] slot_rd_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [3:0]  out_byte_en;
    logic [31:0] rx_frame_cnt;
    logic [31:0] rx_drop_cnt;
    logic        rx_overrun;
    state_t      dbg_state;

    ethpipe_rx_slot_reader dut (
        .pci_clk         (pci_clk),
        .sys_rst         (sys_rst),
        .slot_rx_complete(slot_rx_complete),
        .slot_rx_empty   (slot_rx_empty),
        .slot_rd_address (slot_rd_address),
        .slot_rd_q       (slot_rd_q),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .out_byte_en     (out_byte_en),
        .rx_frame_cnt    (rx_frame_cnt),
        .rx_drop_cnt     (rx_drop_cnt),
        .rx_overrun      (rx_overrun),
        .dbg_state       (dbg_state)
    );

    // clock / slot RAM with one-cycle read latency
    always #4 pci_clk = ~pci_clk;

    logic [31:0] slot_mem [0:2047];
    always @(posedge pci_clk) slot_rd_q <= slot_mem[slot_rd_address];

    int checks = 0;
    int passes = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    logic exp_overrun = 1'b0;
    logic [37:0] exp_q[$];

    // Fill the slot and, for an accepted length, queue the record it should produce.
    task automatic load_frame(input int len, output bit accepted, output int n_total);
        int n;
        logic [3:0] be;
        logic [31:0] w;
        n = (len + 3) / 4;
        n_total = 4 + n;
        accepted = (len >= 1) && (len <= 1536);
        be = (len % 4 == 0) ? 4'hf : 4'((1 << (len % 4)) - 1);
        for (int i = 1; i <= 4 + n; i++) begin
            w = $urandom;
            if (i == 4) w = 32'(len);
            slot_mem[i] = w;
            if (accepted)
                exp_q.push_back({w, (i == 1), (i == 4 + n), (i == 4 + n) ? be : 4'hf});
        end
    endtask

    task automatic run_frame(input int len, input int mode, input int inject_at,
                             output int first_valid, output int empty_at, output int npop);
        logic [37:0] cur, prev, exp;
        logic [3:0] pat;
        logic stalled, done;
        bit acc;
        int n_total, last_pop;
        pat = 4'b1001;
        load_frame(len, acc, n_total);
        if (acc) exp_frames++; else exp_drops++;
        if (inject_at > 0) exp_overrun = 1'b1;
        @(posedge pci_clk); #1;
        slot_rx_complete = 1'b1;
        out_ready = 1'b1;
        first_valid = -1; empty_at = -1; npop = 0; last_pop = -1;
        stalled = 1'b0; prev = '0; done = 1'b0;
        for (int c = 1; c < 4000 && !done; c++) begin
            @(posedge pci_clk); #1;
            slot_rx_complete = (c == inject_at);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[c % 4];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge pci_clk);
            cur = {out_data, out_sop, out_eop, out_byte_en};
            if (c == 1) begin
                checks++;
                if (slot_rx_empty !== 1'b0) $display("FAIL empty_low len=%0d: got %b want 0", len, slot_rx_empty);
                else passes++;
            end
            if (stalled) begin
                checks++;
                if (cur !== prev || out_valid !== 1'b1)
                    $display("FAIL stall_hold len=%0d c=%0d: got %h/%b want %h/1", len, c, cur, out_valid, prev);
                else passes++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_word len=%0d c=%0d: got %h want none", len, c, cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur !== exp) $display("FAIL word len=%0d idx=%0d: got %h want %h", len, npop, cur, exp);
                    else passes++;
                end
                npop++;
                last_pop = c;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            stalled = out_valid && !out_ready;
            prev = cur;
            if (c > 1 && slot_rx_empty && empty_at < 0) empty_at = c;
            if (empty_at >= 0 && exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) $display("FAIL timeout len=%0d: got pending=%0d want 0", len, exp_q.size());
        else passes++;
        checks++;
        if (npop !== (acc ? n_total : 0)) $display("FAIL word_count len=%0d: got %0d want %0d", len, npop, acc ? n_total : 0);
        else passes++;
        if (acc) begin
            checks++;
            if (empty_at !== last_pop + 1) $display("FAIL empty_timing len=%0d: got %0d want %0d", len, empty_at, last_pop + 1);
            else passes++;
        end
        exp_q.delete();
        @(posedge pci_clk); #1;
        out_ready = 1'b1;
        slot_rx_complete = 1'b0;
        repeat (2) @(posedge pci_clk);
        @(negedge pci_clk);
        checks++;
        if (rx_frame_cnt !== 32'(exp_frames)) $display("FAIL frame_cnt: got %0d want %0d", rx_frame_cnt, exp_frames);
        else passes++;
        checks++;
        if (rx_drop_cnt !== 32'(exp_drops)) $display("FAIL drop_cnt: got %0d want %0d", rx_drop_cnt, exp_drops);
        else passes++;
        checks++;
        if (rx_overrun !== exp_overrun || slot_rx_empty !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL idle_after: got ovr=%b empty=%b valid=%b want %b/1/0", rx_overrun, slot_rx_empty, out_valid, exp_overrun);
        else passes++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; slot_rx_complete = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge pci_clk);
        @(negedge pci_clk);
        checks++;
        if (slot_rx_empty !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_ctrl: got %b%b want 10", slot_rx_empty, out_valid);
        else passes++;
        checks++;
        if ({out_data, out_sop, out_eop, out_byte_en} !== 38'd0) $display("FAIL reset_word: got %h want 0", {out_data, out_sop, out_eop, out_byte_en});
        else passes++;
        checks++;
        if (slot_rd_address !== 11'd0 || rx_frame_cnt !== 32'd0 || rx_drop_cnt !== 32'd0 || rx_overrun !== 1'b0)
            $display("FAIL reset_regs: got %0d %0d %0d %b want 0 0 0 0", slot_rd_address, rx_frame_cnt, rx_drop_cnt, rx_overrun);
        else passes++;
        checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
        else passes++;
        @(posedge pci_clk); #1;
        sys_rst = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_basic();
        int fv, ea, np;
        run_frame(64, 0, 0, fv, ea, np);
        checks++;
        if (fv !== 5) $display("FAIL latency: got %0d want 5", fv);
        else passes++;
    endtask

    task automatic test_byte_en();
        int fv, ea, np;
        run_frame(61, 0, 0, fv, ea, np);
        run_frame(62, 0, 0, fv, ea, np);
        run_frame(63, 0, 0, fv, ea, np);
    endtask

    task automatic test_backpressure();
        int fv, ea, np;
        run_frame(60, 1, 0, fv, ea, np);
        run_frame(int'($urandom_range(1, 200)), 2, 0, fv, ea, np);
    endtask

    task automatic test_drop();
        int fv, ea, np;
        run_frame(0, 0, 0, fv, ea, np);
        checks++;
        if (fv !== -1 || ea < 0 || ea > 4) $display("FAIL drop_len0: got valid_at=%0d empty_at=%0d want -1/<=4", fv, ea);
        else passes++;
        run_frame(1600, 0, 0, fv, ea, np);
        checks++;
        if (fv !== -1 || ea < 0 || ea > 4) $display("FAIL drop_len1600: got valid_at=%0d empty_at=%0d want -1/<=4", fv, ea);
        else passes++;
    endtask

    task automatic test_overrun();
        int fv, ea, np;
        run_frame(100, 0, 9, fv, ea, np);
    endtask

    task automatic test_reset_mid_stream();
        bit acc;
        int n_total, fv, ea, np;
        load_frame(60, acc, n_total);
        exp_q.delete();
        @(posedge pci_clk); #1;
        slot_rx_complete = 1'b1;
        out_ready = 1'b1;
        @(posedge pci_clk); #1;
        slot_rx_complete = 1'b0;
        repeat (10) @(posedge pci_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || slot_rx_empty !== 1'b1 || slot_rd_address !== 11'd0)
            $display("FAIL async_reset: got valid=%b empty=%b addr=%0d want 0/1/0", out_valid, slot_rx_empty, slot_rd_address);
        else passes++;
        checks++;
        if (dbg_state !== ST_IDLE || rx_frame_cnt !== 32'd0 || rx_overrun !== 1'b0)
            $display("FAIL async_reset_regs: got st=%0d cnt=%0d ovr=%b want %0d/0/0", dbg_state, rx_frame_cnt, rx_overrun, ST_IDLE);
        else passes++;
        exp_frames = 0; exp_drops = 0; exp_overrun = 1'b0;
        @(posedge pci_clk); #1;
        sys_rst = 1'b0;
        run_frame(4, 0, 0, fv, ea, np);
    endtask

    task automatic test_back_to_back();
        int fv, ea, np;
        int lens[4];
        lens[0] = 1;
        lens[1] = 1536;
        lens[2] = int'($urandom_range(1, 1536));
        lens[3] = int'($urandom_range(1537, 2047));
        for (int i = 0; i < 4; i++) run_frame(lens[i], 2, 0, fv, ea, np);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_en();
        test_backpressure();
        test_drop();
        test_overrun();
        test_reset_mid_stream();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ethpipe_rx_slot_reader.md
Name: ethpipe_rx_slot_reader

Overview:
- Downstream consumer of the Ethernet RX frame slot, in the PCI clock domain.
- Waits for the one-cycle "frame complete" pulse from the GMII receive path, then reads the slot RAM: header words 1–4 and frame data words from 5.
- Streams the header and data as 32-bit words with valid/ready handshake to the host DMA/FIFO.
- Releases the slot back to the receiver by raising slot_rx_empty.

Parameters:
- MAX_FRAME_LEN, 1536: largest accepted frame length in bytes. Longer frames are dropped.
- MIN_FRAME_LEN, 1: smallest accepted frame length in bytes. Shorter frames, including 0, are dropped.

Ports:
- pci_clk  in  1  sole clock, 125 MHz.
- sys_rst  in  1  asynchronous, active-high reset.
- slot_rx_complete  in  1  one-cycle pulse: the slot holds a complete frame.
- slot_rx_empty  out  1  1 = slot free for the receiver.
- slot_rd_address  out  11  slot RAM read word address.
- slot_rd_q  in  32  slot RAM read data; valid exactly 1 cycle after the address.
- out_data  out  32  stream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when valid and ready are both high.
- out_sop  out  1  first word of a record (timestamp low).
- out_eop  out  1  last word of a record.
- out_byte_en  out  4  valid bytes of the word. 4'b1111 except on the final data word.
- rx_frame_cnt  out  32  frames forwarded; wraps.
- rx_drop_cnt  out  32  frames dropped for length; wraps.
- rx_overrun  out  1  sticky: slot_rx_complete arrived while busy.

Behaviour:
- Reset values: slot_rx_empty=1; out_valid=0; out_sop, out_eop=0; out_byte_en=0; out_data=0; slot_rd_address=0; counters=0; rx_overrun=0; state IDLE; skid buffer empty.
- Slot layout (32-bit words, little-endian bytes):
  - word 1: timestamp[31:0]
  - word 2: timestamp[63:32]
  - word 3: hash
  - word 4: {21'b0, len[10:0]}
  - words 5..4+N: frame bytes, N = (len+3)>>2, computed 10 bits wide.
- States:
  - IDLE: on slot_rx_complete → set slot_rx_empty=0, drive slot_rd_address=4, go to LEN.
  - LEN: one wait cycle for read latency, then go to CHECK.
  - CHECK: capture len=slot_rd_q[10:0] and compute N, last_addr=4+N (11 bits, max 516).
    - If len<MIN_FRAME_LEN or len>MAX_FRAME_LEN → DROP.
    - Otherwise → STREAM, with the read pointer at 1.
  - STREAM: issue reads for addresses 1..last_addr, one per cycle, while (skid occupancy + reads in flight) < 2. Every returned word goes into the skid. Once last_addr has been issued and the skid has drained → DONE.
  - DROP: increment rx_drop_cnt, then → DONE.
  - DONE: set slot_rx_empty=1. Increment rx_frame_cnt only if the frame was forwarded. Next state IDLE.
- Stream tagging:
  - out_sop=1 on the word from address 1.
  - out_eop=1 on the word from last_addr.
  - out_byte_en on the last word follows len[1:0]: 00→1111, 01→0001, 10→0011, 11→0111.
- Handshake:
  - out_data, out_valid, out_sop, out_eop and out_byte_en are held stable while out_valid=1 and out_ready=0.
  - No combinational path from out_ready to out_valid.
  - Sustained throughput is 1 word per cycle when out_ready is held high.
- Latency: from the slot_rx_complete cycle to the first out_valid is 5 cycles (IDLE→LEN→CHECK→read issue→skid).
- slot_rx_complete outside IDLE: ignored and rx_overrun set. It never restarts or corrupts the current record.
- slot_rx_empty rises only in DONE, the cycle after the final word handshake or the drop decision.
- Reset mid-record: all state is cleared immediately. The partial stream is abandoned and the slot is reported empty.

Decomposition:
- Shared package ethpipe_pkg holds:
  - slot word address constants SLOT_TS_LO=1, SLOT_TS_HI=2, SLOT_HASH=3, SLOT_LEN=4, SLOT_DATA=5;
  - the length field width (11);
  - the state enumeration.
- One sub-module, ethpipe_skid2: a 2-entry FIFO carrying {data, sop, eop, byte_en} with valid/ready on both sides and an occupancy output.

Test Plan:
- len=64, out_ready=1 → 20 words: sop on ts_lo, eop on word 20 with byte_en 1111. slot_rx_empty returns to 1 and rx_frame_cnt=1.
- len=61 → 20 words with final byte_en 0001. len=62 → final byte_en 0011. len=63 → final byte_en 0111.
- len=60, out_ready toggling 1,0,0,1 repeatedly → no lost or duplicated words, and outputs stay stable while stalled.
- len=0 and len=1600 → no out_valid, rx_drop_cnt=2, slot_rx_empty=1 within 4 cycles of each pulse.
- Second slot_rx_complete pulse during STREAM → current record completes intact and rx_overrun=1.
- sys_rst asserted mid-STREAM → outputs take reset values asynchronously. A following len=4 frame → 5 words.
